// File: rtl/alu_entry_pkg.sv
// Shared types and constants for the operand entry block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_entry_pkg;

    // Entry FSM states; encodings are shown on a display, so keep them fixed.
    typedef enum logic [2:0] {
        A_LO  = 3'd0,
        A_HI  = 3'd1,
        B_LO  = 3'd2,
        B_HI  = 3'd3,
        OP    = 3'd4,
        VALID = 3'd5
    } entry_state_t;

    // 10 ms of stable level at 50 MHz.
    localparam int DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/alu_operand_entry_key_debounce.sv
// Per-key two-flop synchronizer, counter debouncer and press pulse generator.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles; press is a registered output.
// Backpressure: none; a held key yields a single pulse on its debounced 1->0 edge.
module key_debounce
    import alu_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    // Synchronize, count consecutive disagreeing cycles, flip level on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= key;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 != level) begin
                if (cnt == TERM) begin
                    level <= sync_2;
                    cnt   <= '0;
                    // Only a released->pressed flip is a press.
                    press <= level;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/alu_operand_entry.sv
// Pushbutton/switch operand entry: builds 32-bit A and B plus a 4-bit opcode, then offers them.
// Latency: outputs update one cycle after a debounced press pulse; optional KEY[2] sign-extend under ALU_ENTRY_SIGNEXT_EN.
// Backpressure: op_valid holds in VALID until op_ready; state returns to A_LO the cycle after acceptance.
module alu_operand_entry
    import alu_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic        CLOCK_50,
    input  logic        RST,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    output logic [31:0] portA,
    output logic [31:0] portB,
    output logic [3:0]  aluop,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [2:0]  entry_state
);

    entry_state_t state, state_nxt;
    logic [31:0]  a_nxt, b_nxt;
    logic [3:0]   op_nxt;
    logic [15:0]  sw_s1, sw_s2;
    logic [3:0]   key_level;
    logic [3:0]   press;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk  (CLOCK_50),
            .rst  (RST),
            .key  (KEY[i]),
            .level(key_level[i]),
            .press(press[i])
        );
    end

    // Switch synchronizer; only the low 16 switches are meaningful.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= SW[15:0];
            sw_s2 <= sw_s1;
        end
    end

    // State and operand registers.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state <= A_LO;
            portA <= '0;
            portB <= '0;
            aluop <= '0;
        end else begin
            state <= state_nxt;
            portA <= a_nxt;
            portB <= b_nxt;
            aluop <= op_nxt;
        end
    end

    // Next state: clear beats everything, VALID only listens to the handshake,
    // then enter, then (optionally) sign-extend entry.
    always_comb begin
        state_nxt = state;
        a_nxt     = portA;
        b_nxt     = portB;
        op_nxt    = aluop;
        if (press[1]) begin
            state_nxt = A_LO;
            a_nxt     = '0;
            b_nxt     = '0;
            op_nxt    = '0;
        end else if (state == VALID) begin
            if (op_ready) begin
                state_nxt = A_LO;
            end
        end else if (press[0]) begin
            case (state)
                A_LO:    begin a_nxt[15:0]  = sw_s2;      state_nxt = A_HI;  end
                A_HI:    begin a_nxt[31:16] = sw_s2;      state_nxt = B_LO;  end
                B_LO:    begin b_nxt[15:0]  = sw_s2;      state_nxt = B_HI;  end
                B_HI:    begin b_nxt[31:16] = sw_s2;      state_nxt = OP;    end
                OP:      begin op_nxt       = sw_s2[3:0]; state_nxt = VALID; end
                default: state_nxt = A_LO;
            endcase
`ifdef ALU_ENTRY_SIGNEXT_EN
        end else if (press[2]) begin
            if (state == A_LO) begin
                a_nxt     = {{16{sw_s2[15]}}, sw_s2};
                state_nxt = B_LO;
            end else if (state == B_LO) begin
                b_nxt     = {{16{sw_s2[15]}}, sw_s2};
                state_nxt = OP;
            end
`endif
        end
    end

    assign op_valid    = (state == VALID);
    assign entry_state = state;

    // KEY[3], the debounced levels and the top switches are intentionally unused.
    logic unused_ok;
    assign unused_ok = ^{SW[17:16], key_level, press[3], press[2]};

endmodule

// File: tb/tb_alu_operand_entry.sv
// Directed bench for alu_operand_entry with a short debounce window.
// Latency: each key press is held and released long enough to clear the debouncer.
// Backpressure: op_ready driven directly by the bench.
module tb_alu_operand_entry;

    logic        CLOCK_50 = 1'b0;
    logic        RST;
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic [31:0] portA, portB;
    logic [3:0]  aluop;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  entry_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  st;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        v;
    } exp_t;

    exp_t sb[$];

    always #5 CLOCK_50 = ~CLOCK_50;

    alu_operand_entry #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RST        (RST),
        .KEY        (KEY),
        .SW         (SW),
        .portA      (portA),
        .portB      (portB),
        .aluop      (aluop),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .entry_state(entry_state)
    );

    task automatic cycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_out(input logic [2:0] st, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic v);
        exp_t e;
        e.st = st; e.a = a; e.b = b; e.op = op; e.v = v;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard_empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_state"}, {29'd0, entry_state}, {29'd0, e.st});
            chk({tag, "_portA"}, portA, e.a);
            chk({tag, "_portB"}, portB, e.b);
            chk({tag, "_aluop"}, {28'd0, aluop}, {28'd0, e.op});
            chk({tag, "_op_valid"}, {31'd0, op_valid}, {31'd0, e.v});
        end
    endtask

    // Press the keys in mask together, hold, then release and let the debouncer settle.
    task automatic press_keys(input logic [3:0] mask);
        KEY = ~mask;
        cycles(10);
        KEY = 4'hF;
        cycles(10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        RST      = 1'b1;
        KEY      = 4'hF;
        SW       = '0;
        op_ready = 1'b0;
        cycles(3);
        expect_out(3'd0, 32'h0, 32'h0, 4'h0, 1'b0);
        check_out("reset");
        RST = 1'b0;
        cycles(20);
        expect_out(3'd0, 32'h0, 32'h0, 4'h0, 1'b0);
        check_out("reset_release_idle");

        // Full entry sequence.
        SW = 18'h01234; press_keys(4'b0001);
        expect_out(3'd1, 32'h0000_1234, 32'h0, 4'h0, 1'b0); check_out("entry_a_lo");
        SW = 18'h00000; press_keys(4'b0001);
        expect_out(3'd2, 32'h0000_1234, 32'h0, 4'h0, 1'b0); check_out("entry_a_hi");
        SW = 18'h00005; press_keys(4'b0001);
        expect_out(3'd3, 32'h0000_1234, 32'h5, 4'h0, 1'b0); check_out("entry_b_lo");
        SW = 18'h00000; press_keys(4'b0001);
        expect_out(3'd4, 32'h0000_1234, 32'h5, 4'h0, 1'b0); check_out("entry_b_hi");
        SW = 18'h00002; press_keys(4'b0001);
        expect_out(3'd5, 32'h0000_1234, 32'h5, 4'h2, 1'b1); check_out("entry_op");

        // Handshake: stall, ignored keys, then accept.
        cycles(10);
        expect_out(3'd5, 32'h0000_1234, 32'h5, 4'h2, 1'b1); check_out("hs_stall");
        SW = 18'h0000F; press_keys(4'b0001);
        expect_out(3'd5, 32'h0000_1234, 32'h5, 4'h2, 1'b1); check_out("hs_key0_ignored");
        press_keys(4'b1100);
        expect_out(3'd5, 32'h0000_1234, 32'h5, 4'h2, 1'b1); check_out("hs_key23_ignored");
        op_ready = 1'b1;
        cycles(1);
        op_ready = 1'b0;
        expect_out(3'd0, 32'h0000_1234, 32'h5, 4'h2, 1'b0); check_out("hs_accept");

        // Bounce on KEY[0], then a clean 6-cycle hold: one advance only.
        SW = 18'h000AB;
        for (int i = 0; i < 10; i++) begin
            KEY[0] = (i % 2 == 1);
            cycles(2);
        end
        KEY[0] = 1'b0;
        cycles(6);
        KEY[0] = 1'b1;
        cycles(12);
        expect_out(3'd1, 32'h0000_00AB, 32'h5, 4'h2, 1'b0); check_out("bounce");

        // KEY[3] does nothing.
        press_keys(4'b1000);
        expect_out(3'd1, 32'h0000_00AB, 32'h5, 4'h2, 1'b0); check_out("key3_ignored");

        // Walk to B_HI, then clear and enter together.
        SW = 18'h00001; press_keys(4'b0001);
        expect_out(3'd2, 32'h0001_00AB, 32'h5, 4'h2, 1'b0); check_out("walk_a_hi");
        SW = 18'h00007; press_keys(4'b0001);
        expect_out(3'd3, 32'h0001_00AB, 32'h7, 4'h2, 1'b0); check_out("walk_b_lo");
        press_keys(4'b0011);
        expect_out(3'd0, 32'h0, 32'h0, 4'h0, 1'b0); check_out("simul_clear");

        // KEY[2] sign-extend entry in A_LO.
        SW = 18'h08001; press_keys(4'b0100);
`ifdef ALU_ENTRY_SIGNEXT_EN
        expect_out(3'd2, 32'hFFFF_8001, 32'h0, 4'h0, 1'b0); check_out("signext");
`else
        expect_out(3'd0, 32'h0, 32'h0, 4'h0, 1'b0); check_out("signext_off");
`endif
        press_keys(4'b0010);
        expect_out(3'd0, 32'h0, 32'h0, 4'h0, 1'b0); check_out("clear");

        // Reach OP, then reset mid-operation.
        SW = 18'h00003;
        repeat (4) press_keys(4'b0001);
        expect_out(3'd4, 32'h0003_0003, 32'h0003_0003, 4'h0, 1'b0); check_out("reach_op");
        RST = 1'b1;
        cycles(1);
        expect_out(3'd0, 32'h0, 32'h0, 4'h0, 1'b0); check_out("rst_in_op");
        RST = 1'b0;
        cycles(20);
        expect_out(3'd0, 32'h0, 32'h0, 4'h0, 1'b0); check_out("rst_no_spurious");
        SW = 18'h00009; press_keys(4'b0001);
        expect_out(3'd1, 32'h0000_0009, 32'h0, 4'h0, 1'b0); check_out("after_rst_entry");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
